// File: rtl/parking_gate_controller.sv
// Shared barrier gate sequencer for a parking lot: arbitrates entry/exit
// requests, drives the gate through open/close, and keeps the occupancy count.
module parking_gate_controller #(
  parameter int unsigned CAPACITY    = 8,
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic       car_passed,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       entry_reject,
  output logic       gate_open,
  output logic       timeout,
  output logic [3:0] parked,
  output logic [3:0] empty,
  output logic       full
);

  localparam int unsigned TimerW = $clog2(GATE_CYCLES + 1);
  localparam logic [3:0] Cap = 4'(CAPACITY);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(GATE_CYCLES);

  typedef enum logic [1:0] {StIdle, StOpen, StClose} state_e;
  typedef enum logic {DirIn, DirOut} dir_e;

  state_e state_q, state_d;
  dir_e   dir_q, dir_d;
  dir_e   last_q, last_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0] parked_q, parked_d;
  logic entry_ack_q, entry_ack_d;
  logic exit_ack_q, exit_ack_d;
  logic entry_reject_q, entry_reject_d;
  logic gate_open_q, gate_open_d;
  logic timeout_q, timeout_d;

  logic entry_ok, exit_ok, grant_in, grant_out;

  assign full  = (parked_q == Cap);
  assign empty = Cap - parked_q;

  // Round-robin on ties: the side opposite the last grant wins.
  assign entry_ok  = entry_req && !full;
  assign exit_ok   = exit_req && (parked_q != 4'd0);
  assign grant_in  = entry_ok && (!exit_ok || (last_q == DirOut));
  assign grant_out = exit_ok && !grant_in;

  // Next-state, count and registered-output decode.
  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    last_d         = last_q;
    timer_d        = timer_q;
    parked_d       = parked_q;
    entry_ack_d    = 1'b0;
    exit_ack_d     = 1'b0;
    entry_reject_d = 1'b0;
    gate_open_d    = 1'b0;
    timeout_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        entry_reject_d = entry_req && full && !grant_out;
        if (grant_in || grant_out) begin
          state_d     = StOpen;
          dir_d       = grant_in ? DirIn : DirOut;
          last_d      = grant_in ? DirIn : DirOut;
          timer_d     = TimerLoad;
          gate_open_d = 1'b1;
          entry_ack_d = grant_in;
          exit_ack_d  = grant_out;
        end
      end
      StOpen: begin
        if (car_passed) begin
          // Saturation is defensive; the grant guards keep the count in range.
          if (dir_q == DirIn) begin
            parked_d = (parked_q >= Cap) ? Cap : parked_q + 4'd1;
          end else begin
            parked_d = (parked_q == 4'd0) ? 4'd0 : parked_q - 4'd1;
          end
          state_d = StClose;
          timer_d = '0;
        end else if (timer_q <= TimerW'(1)) begin
          timer_d   = '0;
          timeout_d = 1'b1;
          state_d   = StClose;
        end else begin
          timer_d     = timer_q - TimerW'(1);
          gate_open_d = 1'b1;
        end
      end
      StClose: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset drops the gate and clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      dir_q          <= DirIn;
      last_q         <= DirOut;
      timer_q        <= '0;
      parked_q       <= 4'd0;
      entry_ack_q    <= 1'b0;
      exit_ack_q     <= 1'b0;
      entry_reject_q <= 1'b0;
      gate_open_q    <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      last_q         <= last_d;
      timer_q        <= timer_d;
      parked_q       <= parked_d;
      entry_ack_q    <= entry_ack_d;
      exit_ack_q     <= exit_ack_d;
      entry_reject_q <= entry_reject_d;
      gate_open_q    <= gate_open_d;
      timeout_q      <= timeout_d;
    end
  end

  assign entry_ack    = entry_ack_q;
  assign exit_ack     = exit_ack_q;
  assign entry_reject = entry_reject_q;
  assign gate_open    = gate_open_q;
  assign timeout      = timeout_q;
  assign parked       = parked_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller (CAPACITY 8, GATE_CYCLES 4).
module tb_parking_gate_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       entry_req, exit_req, car_passed;
  logic       entry_ack, exit_ack, entry_reject, gate_open, timeout, full;
  logic [3:0] parked, empty;

  int n_checks = 0;
  int n_fail   = 0;

  parking_gate_controller #(.CAPACITY(8), .GATE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .car_passed  (car_passed),
    .entry_ack   (entry_ack),
    .exit_ack    (exit_ack),
    .entry_reject(entry_reject),
    .gate_open   (gate_open),
    .timeout     (timeout),
    .parked      (parked),
    .empty       (empty),
    .full        (full)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with the pass on the first open cycle.
  task automatic car_cycle(input bit is_entry, input logic [3:0] exp_parked);
    entry_req = is_entry;
    exit_req  = !is_entry;
    step();
    if ((is_entry ? entry_ack : exit_ack) !== 1'b1) begin
      $display("FAIL car_cycle_ack: got %b want 1 (entry=%0b)",
               is_entry ? entry_ack : exit_ack, is_entry);
      n_fail++;
    end
    n_checks++;
    entry_req  = 1'b0;
    exit_req   = 1'b0;
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
    if (parked !== exp_parked) begin
      $display("FAIL car_cycle_parked: got %0d want %0d", parked, exp_parked);
      n_fail++;
    end
    n_checks++;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; car_passed = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    if (parked !== 4'd0) begin
      $display("FAIL reset_parked: got %0d want 0", parked); n_fail++;
    end
    n_checks++;
    if (empty !== 4'd8) begin
      $display("FAIL reset_empty: got %0d want 8", empty); n_fail++;
    end
    n_checks++;
    if ({full, gate_open, entry_ack, exit_ack, entry_reject, timeout} !== 6'b0) begin
      $display("FAIL reset_flags: got %b want 000000",
               {full, gate_open, entry_ack, exit_ack, entry_reject, timeout});
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_exit_when_empty();
    exit_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if ({exit_ack, gate_open} !== 2'b00) begin
        $display("FAIL empty_exit: got ack=%b gate=%b want 0 0", exit_ack, gate_open);
        n_fail++;
      end
      n_checks++;
    end
    exit_req = 1'b0;
  endtask

  task automatic test_single_entry();
    entry_req = 1'b1;
    step();
    if ({entry_ack, gate_open} !== 2'b11) begin
      $display("FAIL single_grant: got ack=%b gate=%b want 1 1", entry_ack, gate_open);
      n_fail++;
    end
    n_checks++;
    entry_req = 1'b0;
    step();
    if ({entry_ack, gate_open} !== 2'b01) begin
      $display("FAIL single_open2: got ack=%b gate=%b want 0 1", entry_ack, gate_open);
      n_fail++;
    end
    n_checks++;
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
    if ({gate_open, parked, empty} !== {1'b0, 4'd1, 4'd7}) begin
      $display("FAIL single_pass: got gate=%b parked=%0d empty=%0d want 0 1 7",
               gate_open, parked, empty);
      n_fail++;
    end
    n_checks++;
    step();
  endtask

  task automatic test_fill_lot();
    for (int i = 2; i <= 8; i++) car_cycle(1'b1, 4'(i));
    if ({full, empty} !== {1'b1, 4'd0}) begin
      $display("FAIL fill_full: got full=%b empty=%0d want 1 0", full, empty);
      n_fail++;
    end
    n_checks++;
    entry_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      if ({entry_reject, entry_ack} !== 2'b10) begin
        $display("FAIL fill_reject: got rej=%b ack=%b want 1 0", entry_reject, entry_ack);
        n_fail++;
      end
      n_checks++;
    end
    exit_req = 1'b1;
    step();
    if ({exit_ack, entry_ack, entry_reject} !== 3'b100) begin
      $display("FAIL fill_exit_grant: got ex=%b en=%b rej=%b want 1 0 0",
               exit_ack, entry_ack, entry_reject);
      n_fail++;
    end
    n_checks++;
    exit_req   = 1'b0;
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
    if (parked !== 4'd7) begin
      $display("FAIL fill_exit_count: got %0d want 7", parked); n_fail++;
    end
    n_checks++;
    step();
    step();
    if ({entry_ack, entry_reject} !== 2'b10) begin
      $display("FAIL fill_pending_ack: got ack=%b rej=%b want 1 0", entry_ack, entry_reject);
      n_fail++;
    end
    n_checks++;
    entry_req  = 1'b0;
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
    step();
    if (parked !== 4'd8) begin
      $display("FAIL fill_refill: got %0d want 8", parked); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    for (int i = 7; i >= 3; i--) car_cycle(1'b0, 4'(i));
    exp = 4'd3;
    entry_req = 1'b1;
    exit_req  = 1'b1;
    for (int g = 0; g < 4; g++) begin
      int k = 0;
      do begin
        step();
        k++;
      end while (!(entry_ack || exit_ack) && k < 10);
      if ({entry_ack, exit_ack} !== ((g % 2 == 0) ? 2'b10 : 2'b01)) begin
        $display("FAIL rr_grant%0d: got en=%b ex=%b want %s", g, entry_ack, exit_ack,
                 (g % 2 == 0) ? "IN" : "OUT");
        n_fail++;
      end
      n_checks++;
      exp = (g % 2 == 0) ? exp + 4'd1 : exp - 4'd1;
      car_passed = 1'b1;
      step();
      car_passed = 1'b0;
      if (parked !== exp) begin
        $display("FAIL rr_parked%0d: got %0d want %0d", g, parked, exp); n_fail++;
      end
      n_checks++;
    end
    entry_req = 1'b0;
    exit_req  = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int cnt = 0;
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    while (gate_open && cnt < 20) begin
      cnt++;
      step();
    end
    if (cnt != 4) begin
      $display("FAIL timeout_open_cycles: got %0d want 4", cnt); n_fail++;
    end
    n_checks++;
    if ({timeout, parked} !== {1'b1, 4'd3}) begin
      $display("FAIL timeout_pulse: got to=%b parked=%0d want 1 3", timeout, parked);
      n_fail++;
    end
    n_checks++;
    step();
    if (timeout !== 1'b0) begin
      $display("FAIL timeout_one_cycle: got %b want 0", timeout); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_edge_cases();
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
    step();
    if (parked !== 4'd3) begin
      $display("FAIL idle_pass: got %0d want 3", parked); n_fail++;
    end
    n_checks++;
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    repeat (3) step();
    if (gate_open !== 1'b1) begin
      $display("FAIL last_cycle_open: got %b want 1", gate_open); n_fail++;
    end
    n_checks++;
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
    if ({parked, timeout, gate_open} !== {4'd4, 1'b0, 1'b0}) begin
      $display("FAIL last_cycle_pass: got parked=%0d to=%b gate=%b want 4 0 0",
               parked, timeout, gate_open);
      n_fail++;
    end
    n_checks++;
    step();
  endtask

  task automatic test_reset_mid_open();
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    if ({gate_open, parked, empty} !== {1'b0, 4'd0, 4'd8}) begin
      $display("FAIL async_reset: got gate=%b parked=%0d empty=%0d want 0 0 8",
               gate_open, parked, empty);
      n_fail++;
    end
    n_checks++;
    @(posedge clk);
    #3 rst_n = 1'b1;
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    if ({entry_ack, gate_open} !== 2'b11) begin
      $display("FAIL post_reset_idle: got ack=%b gate=%b want 1 1", entry_ack, gate_open);
      n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_exit_when_empty();
    test_single_entry();
    test_fill_lot();
    test_back_to_back();
    test_timeout();
    test_edge_cases();
    test_reset_mid_open();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/parking_gate_controller.md
# parking_gate_controller

Sequences the single shared barrier gate of the smart parking lot between the entry lane and the exit lane, and keeps the occupancy count. It arbitrates competing entry/exit requests and rejects entry when the lot is full. It opens the gate, waits for the pass sensor or a timeout, then closes the gate. It owns the registered `parked` count and derives `empty` = CAPACITY − `parked` for the display and status logic downstream.

## Interface
- CAPACITY, 8, number of spots; 1..15; count width fixed at 4 bits
- GATE_CYCLES, 4, maximum cycles the gate stays open waiting for `car_passed`; ≥1

- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- entry_req  in  1  level; car waiting at entry; held until `entry_ack` or `entry_reject`
- exit_req  in  1  level; car waiting at exit; held until `exit_ack`
- car_passed  in  1  gate sensor; single-cycle pulse when a car clears the barrier
- entry_ack  out  1  one-cycle pulse; entry granted
- exit_ack  out  1  one-cycle pulse; exit granted
- entry_reject  out  1  entry refused because lot is full
- gate_open  out  1  barrier raise command
- timeout  out  1  one-cycle pulse; gate closed without a pass
- parked  out  4  cars currently inside, 0..CAPACITY
- empty  out  4  CAPACITY − `parked`
- full  out  1  `parked` == CAPACITY

## Operation
- FSM states: IDLE, OPEN, CLOSE. A direction register `dir` holds IN or OUT. A priority pointer `last` holds the last grant direction and resets to OUT, so entry wins the first tie.
- IDLE:
  - Entry is eligible when `entry_req` && !`full`. Exit is eligible when `exit_req` && `parked` != 0.
  - If both are eligible, grant the direction opposite to `last`. Otherwise grant whichever is eligible.
  - A grant pulses the matching ack, sets `dir` and `last`, loads the timer with GATE_CYCLES, and moves to OPEN.
  - `entry_req` && `full` asserts `entry_reject` for every IDLE cycle in which exit is not granted.
  - `exit_req` with `parked` == 0 is ignored: no ack and no error.
- OPEN: `gate_open` = 1.
  - On `car_passed`: `parked` +1 if `dir` = IN, −1 if OUT; go to CLOSE.
  - Otherwise the timer decrements. When it reaches 0, pulse `timeout` and go to CLOSE with no count change.
  - `car_passed` has priority over expiry in the same cycle.
- CLOSE: `gate_open` = 0 for exactly one cycle, then go to IDLE.
- Requests arriving outside IDLE stay pending. `car_passed` outside OPEN is ignored.
- Count arithmetic saturates: never above CAPACITY, never below 0. Guards already prevent both cases, so saturation is defensive only.
- `empty` and `full` are combinational from registered `parked`.

## Timing
- Reset values: state IDLE, `parked` 0, `empty` CAPACITY, `full` 0, `gate_open` 0, all pulses 0, `last` OUT, timer 0.
- Reset is honoured mid-operation. The gate drops immediately and the count clears.
- All outputs except `empty`/`full` are registered.
- Request sampled high at edge T in IDLE: the ack is high and `gate_open` is high in cycle T+1.
- `car_passed` sampled at edge P in OPEN: `parked`/`empty` update and `gate_open` = 0 from cycle P+1. The next grant is possible at edge P+2 at the earliest.
- Timeout path: `gate_open` is high for exactly GATE_CYCLES cycles. `timeout` pulses in the cycle after the last open cycle, coincident with CLOSE.
- `entry_reject` is high in the cycle after sampling `entry_req` && `full` in IDLE.
- Minimum grant-to-grant spacing: 3 cycles (OPEN ≥1, CLOSE 1, IDLE sample).

## Test plan
- Reset: assert `rst_n`=0 mid-OPEN. Required: `gate_open`=0 asynchronously, `parked`=0, `empty`=8, state IDLE after release.
- Single entry: `entry_req` for 1 cycle, then `car_passed` 2 cycles after the ack. Required: `entry_ack` pulse, `gate_open` high for 2 cycles, then `parked`=1, `empty`=7.
- Fill lot: 8 entries, then a 9th `entry_req`. Required: `full`=1, `empty`=0, `entry_reject` high, no ack. One exit then grants, after which the pending entry is acked and `parked` returns to 8.
- Simultaneous requests: `entry_req` and `exit_req` held with `parked`=3. Required grant order is IN, OUT, IN, OUT. `parked` stays 3 after each IN/OUT pair.
- Timeout: grant entry, no `car_passed`. Required: `gate_open` high for exactly 4 cycles, `timeout` pulse, `parked` unchanged.
- Edge cases:
  - `exit_req` at `parked`=0: no ack.
  - `car_passed` in IDLE: no count change.
  - `car_passed` on the final timer cycle: counted, no `timeout`.
